hs_slave_fifo: RTL and testbench
================================

HS_SLAVE_FIFO -- requirements
Module: hs_slave_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  DATA_WIDTH  upstream payload.
REQ-006 SHALL have port valid_in  input  1  upstream payload valid.
REQ-007 SHALL have port ready_out  output  1  slave can accept data this cycle.
REQ-008 SHALL have port data_out  output  DATA_WIDTH  head-of-buffer payload to downstream.
REQ-009 SHALL have port valid_out  output  1  data_out valid.
REQ-010 SHALL have port ready_in  input  1  downstream accepts data_out.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port proto_err  output  1  sticky upstream protocol violation flag; present only with HS_SLAVE_PROTO_CHECK_EN.

Function
REQ-013 SHALL accept (push) when valid_in && ready_out at a rising clk edge.
REQ-014 SHALL release (pop) when valid_out && ready_in at a rising clk edge.
REQ-015 SHALL drive ready_out = (level != DEPTH), combinationally from registered state only; no path from valid_in or ready_in.
REQ-016 SHALL drive valid_out = (level != 0) and data_out = entry at read pointer (first-word fall-through).
REQ-017 SHALL present a pushed word on data_out with valid_out high in the cycle after the push when the buffer was empty (latency 1); no same-cycle bypass.
REQ-018 SHALL track occupancy in a state register: EMPTY (level 0), PARTIAL (0<level<DEPTH), FULL (level DEPTH).
REQ-019 SHALL transition EMPTY->PARTIAL on push; PARTIAL->FULL on push-only reaching DEPTH; PARTIAL->EMPTY on pop-only reaching 0; FULL->PARTIAL on pop; all other cases hold state.
REQ-020 SHALL, on simultaneous push and pop in PARTIAL, leave level unchanged and advance both pointers.
REQ-021 SHALL, when FULL, ignore valid_in (ready_out low); a pop in the same cycle does not enable a push until the next cycle.
REQ-022 SHALL, when EMPTY, ignore ready_in; level never underflows.
REQ-023 SHALL wrap read/write pointers from DEPTH-1 to 0.
REQ-024 SHALL hold data_out stable while valid_out && !ready_in.

Reset
REQ-025 SHALL, on rst low, immediately clear pointers and level, set state EMPTY, valid_out 0, and proto_err 0 (when present); ready_out becomes 1.
REQ-026 SHALL discard buffered data on reset mid-operation; storage contents need not be cleared.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-028 SHALL, with HS_SLAVE_PROTO_CHECK_EN defined, set proto_err at the next edge when, after a cycle with valid_in && !ready_out, valid_in drops or data_in changes before acceptance; flag holds until reset.
REQ-029 SHALL, without HS_SLAVE_PROTO_CHECK_EN, omit the proto_err port and all checker logic; datapath behaviour is identical.

Structure
REQ-030 SHALL take the occupancy-state enum (EMPTY, PARTIAL, FULL) and default DATA_WIDTH/DEPTH constants from shared package hs_pkg.
REQ-031 SHALL place storage in sub-module hs_fifo_mem (DEPTH x DATA_WIDTH, one write port, one asynchronous read port, no reset).

Verification (DATA_WIDTH 8, DEPTH 4)
REQ-032 SHALL cover: reset pulse -> level 0, valid_out 0, ready_out 1.
REQ-033 SHALL cover: push 8'hD4 with ready_in 0 -> next cycle valid_out 1, data_out 8'hD4, level 1.
REQ-034 SHALL cover: push 8'h4D, 8'h00, 8'hFF, 8'h11 with ready_in 0 -> level 4, ready_out 0; fifth word 8'h22 is not accepted.
REQ-035 SHALL cover: ready_in 1 after fill -> pops in order 8'h4D, 8'h00, 8'hFF, 8'h11; 8'h22 accepted only after ready_out returns high; pointer wrap exercised.
REQ-036 SHALL cover: continuous push and pop at level 2 for 10 cycles -> level constant 2, output order equals input order.
REQ-037 SHALL cover: with macro, stall valid_in at FULL, then change data_in 8'hAA->8'hBB -> proto_err 1 next cycle, stays 1 until rst low.

Source files
------------

// File: rtl/hs_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the handshake slave FIFO:
//   - occ_state_e   : buffer occupancy state (EMPTY / PARTIAL / FULL)
//   - HS_DATA_WIDTH : default payload width
//   - HS_DEPTH      : default buffer depth (power of two, >= 2)
// -----------------------------------------------------------------------------
package hs_pkg;

  localparam int HS_DATA_WIDTH = 8;
  localparam int HS_DEPTH      = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage : hs_pkg

// File: rtl/hs_fifo_mem.sv
// -----------------------------------------------------------------------------
// hs_fifo_mem
// DEPTH x DATA_WIDTH storage array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module hs_fifo_mem
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = HS_DATA_WIDTH,
  parameter int DEPTH      = HS_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : hs_fifo_mem

// File: rtl/hs_slave_fifo.sv
// -----------------------------------------------------------------------------
// hs_slave_fifo
// Valid/ready slave buffer with first-word fall-through output.
// Push on valid_in && ready_out, pop on valid_out && ready_in. ready_out and
// valid_out are derived from registered occupancy only, so neither handshake
// input has a combinational path to the outputs.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   data_in    in   upstream payload
//   valid_in   in   upstream payload valid
//   ready_out  out  buffer can accept this cycle (level != DEPTH)
//   data_out   out  head-of-buffer payload
//   valid_out  out  data_out valid (level != 0)
//   ready_in   in   downstream accepts data_out
//   level      out  occupancy 0..DEPTH
//   proto_err  out  sticky upstream protocol violation (only with macro)
//
// Build option:
//   HS_SLAVE_PROTO_CHECK_EN - adds proto_err and the upstream stability
//   checker. Without it the port and checker are absent; the datapath is
//   unchanged.
// -----------------------------------------------------------------------------
module hs_slave_fifo
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = HS_DATA_WIDTH,
  parameter int DEPTH      = HS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   level
`ifdef HS_SLAVE_PROTO_CHECK_EN
  ,
  output logic                     proto_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_LAST = LW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  occ_state_e      state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic            push, pop;

  assign ready_out = (level_q != LVL_FULL);
  assign valid_out = (level_q != '0);
  assign level     = level_q;

  // valid_out gates pop, so ready_in is ignored while empty.
  assign push = valid_in  & ready_out;
  assign pop  = valid_out & ready_in;

  // Pointers wrap DEPTH-1 -> 0 by natural overflow (DEPTH is a power of two).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push) state_d = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (push && !pop && (level_q == LVL_LAST)) begin
          state_d = OCC_FULL;
        end else if (pop && !push && (level_q == LVL_ONE)) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) state_d = OCC_PARTIAL;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OCC_EMPTY;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  hs_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (data_in),
    .raddr_i (rptr_q),
    .rdata_o (data_out)
  );

`ifdef HS_SLAVE_PROTO_CHECK_EN
  // Once the upstream has offered a word that was refused, it must keep
  // valid_in high with the same data until the word is taken.
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] stall_data_q;
  logic                  proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q;
    if (stall_q && (!valid_in || (data_in != stall_data_q))) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      stall_q     <= valid_in & ~ready_out;
      proto_err_q <= proto_err_d;
    end
  end

  // Only meaningful while stall_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    stall_data_q <= data_in;
  end

  assign proto_err = proto_err_q;
`endif

endmodule : hs_slave_fifo

// File: tb/tb_hs_slave_fifo.sv
// -----------------------------------------------------------------------------
// tb_hs_slave_fifo
// Directed bench for hs_slave_fifo (DATA_WIDTH 8, DEPTH 4). Inputs change
// 1 ns after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_hs_slave_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_in = 1'b0;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic [2:0] level;
`ifdef HS_SLAVE_PROTO_CHECK_EN
  logic       proto_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hs_slave_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .level     (level)
`ifdef HS_SLAVE_PROTO_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = 8'h00;
    #2;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
`ifdef HS_SLAVE_PROTO_CHECK_EN
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_push();
    valid_in = 1'b1; data_in = 8'hD4; ready_in = 1'b0;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b want 0", valid_out); end
    tick();
    valid_in = 1'b0; data_in = 8'h00;
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL single_valid_out: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 8'hD4) begin n_err++; $display("FAIL single_data_out: got %h want d4", data_out); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
    tick();
    n_cmp++; if (data_out !== 8'hD4) begin n_err++; $display("FAIL single_hold_data: got %h want d4", data_out); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL single_hold_level: got %0d want 1", level); end
  endtask

  task automatic test_reset_discard();
    rst = 1'b0;
    #1;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL discard_level: got %0d want 0", level); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL discard_valid_out: got %b want 0", valid_out); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL discard_after_level: got %0d want 0", level); end
  endtask

  task automatic test_fill();
    logic [7:0] words [4];
    words[0] = 8'h4D; words[1] = 8'h00; words[2] = 8'hFF; words[3] = 8'h11;
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = words[i];
      tick();
      n_cmp++; if (level !== 3'(i + 1)) begin n_err++; $display("FAIL fill_level_%0d: got %0d want %0d", i, level, i + 1); end
      n_cmp++; if (data_out !== 8'h4D) begin n_err++; $display("FAIL fill_head_%0d: got %h want 4d", i, data_out); end
    end
    valid_in = 1'b1; data_in = 8'h22;
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL fill_ready_out: got %b want 0", ready_out); end
    tick();
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fill_refuse_level: got %0d want 4", level); end
    n_cmp++; if (data_out !== 8'h4D) begin n_err++; $display("FAIL fill_refuse_head: got %h want 4d", data_out); end
  endtask

  // Entered FULL with 8'h22 still offered; drains through the pointer wrap.
  task automatic test_drain();
    ready_in = 1'b1; valid_in = 1'b1; data_in = 8'h22;
    tick();
    n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL drain1_level: got %0d want 3", level); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL drain1_data: got %h want 00", data_out); end
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL drain1_ready_out: got %b want 1", ready_out); end
    tick();
    valid_in = 1'b0; data_in = 8'h00;
    n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL drain2_level: got %0d want 3", level); end
    n_cmp++; if (data_out !== 8'hFF) begin n_err++; $display("FAIL drain2_data: got %h want ff", data_out); end
    tick();
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL drain3_level: got %0d want 2", level); end
    n_cmp++; if (data_out !== 8'h11) begin n_err++; $display("FAIL drain3_data: got %h want 11", data_out); end
    tick();
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL drain4_level: got %0d want 1", level); end
    n_cmp++; if (data_out !== 8'h22) begin n_err++; $display("FAIL drain4_data: got %h want 22", data_out); end
    tick();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL drain5_level: got %0d want 0", level); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL drain5_valid_out: got %b want 0", valid_out); end
    tick();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL empty_pop_level: got %0d want 0", level); end
`ifdef HS_SLAVE_PROTO_CHECK_EN
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL drain_proto_err: got %b want 0", proto_err); end
`endif
    ready_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    ready_in = 1'b0;
    valid_in = 1'b1; data_in = 8'hA0; tick();
    data_in = 8'hA1; tick();
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_prefill_level: got %0d want 2", level); end
    ready_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      data_in = 8'(8'hB0 + k - 1);
      tick();
      exp = (k == 1) ? 8'hA1 : 8'(8'hB0 + k - 2);
      n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level_%0d: got %0d want 2", k, level); end
      n_cmp++; if (data_out !== exp) begin n_err++; $display("FAIL b2b_data_%0d: got %h want %h", k, data_out, exp); end
    end
    valid_in = 1'b0; data_in = 8'h00;
    tick();
    n_cmp++; if (data_out !== 8'hB9) begin n_err++; $display("FAIL b2b_tail_data: got %h want b9", data_out); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL b2b_tail_level: got %0d want 1", level); end
    tick();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL b2b_empty_level: got %0d want 0", level); end
    ready_in = 1'b0;
  endtask

`ifdef HS_SLAVE_PROTO_CHECK_EN
  task automatic test_proto_err();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = 8'(8'h30 + i);
      tick();
    end
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL proto_full_level: got %0d want 4", level); end
    valid_in = 1'b1; data_in = 8'hAA;
    tick();
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_stall_ok: got %b want 0", proto_err); end
    data_in = 8'hBB;
    tick();
    n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_set: got %b want 1", proto_err); end
    valid_in = 1'b0; data_in = 8'h00;
    tick(); tick();
    n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_clear: got %b want 0", proto_err); end
    @(negedge clk);
    rst = 1'b1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_push();
    test_reset_discard();
    test_fill();
    test_drain();
    test_back_to_back();
`ifdef HS_SLAVE_PROTO_CHECK_EN
    test_proto_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_hs_slave_fifo
